// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and DRAM.
// Read hits complete in the request cycle; read misses refill a whole line one word at a time.
module dcache_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int WORD_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_rw,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [WORD_W-1:0]   cpu_wdata,
  input  logic [WORD_W/8-1:0] cpu_be,
  output logic [WORD_W-1:0]   cpu_rdata,
  output logic                cpu_ready,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic [WORD_W/8-1:0] mem_be,
  input  logic [WORD_W-1:0]   mem_rdata,
  input  logic                mem_ack
);
  localparam int BE_W  = WORD_W / 8;
  localparam int WL_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - WL_W - 2;
  localparam logic [WL_W-1:0] CNT_LAST = {WL_W{1'b1}};
  localparam logic [WL_W-1:0] CNT_ONE  = WL_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [WORD_W-1:0] data_r [LINES][WORDS_PER_LINE];
  logic [WL_W-1:0]   cnt_r;
  logic [ADDR_W-3:0] lat_addr_r;
  logic [WORD_W-1:0] lat_wdata_r;
  logic [BE_W-1:0]   lat_be_r;

  logic [TAG_W-1:0] cpu_tag_s, lat_tag_s;
  logic [IDX_W-1:0] cpu_idx_s, lat_idx_s;
  logic [WL_W-1:0]  cpu_word_s, lat_word_s;
  logic             cpu_hit_s, lat_hit_s;
  logic             unused_ok_s;

  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_w,
                                                    input logic [WORD_W-1:0] new_w,
                                                    input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // The byte offset is ignored: all accesses are word-aligned.
  assign unused_ok_s = &{1'b0, cpu_addr[1:0]};

  assign cpu_word_s = cpu_addr[2 +: WL_W];
  assign cpu_idx_s  = cpu_addr[2 + WL_W +: IDX_W];
  assign cpu_tag_s  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign lat_word_s = lat_addr_r[0 +: WL_W];
  assign lat_idx_s  = lat_addr_r[WL_W +: IDX_W];
  assign lat_tag_s  = lat_addr_r[ADDR_W-3 -: TAG_W];

  assign cpu_hit_s = cpu_req && valid_r[cpu_idx_s] && (tag_r[cpu_idx_s] == cpu_tag_s);
  assign lat_hit_s = valid_r[lat_idx_s] && (tag_r[lat_idx_s] == lat_tag_s);
  assign busy      = (state_r != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, CPU response and DRAM request decode.
  always_comb begin
    state_next_s = state_r;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req && cpu_rw) begin
          state_next_s = ST_WRITE;
        end else if (cpu_hit_s) begin
          cpu_ready = 1'b1;
          cpu_rdata = data_r[cpu_idx_s][cpu_word_s];
        end else if (cpu_req) begin
          state_next_s = ST_REFILL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_be   = {BE_W{1'b1}};
        mem_addr = {lat_tag_s, lat_idx_s, cnt_r, 2'b00};
        if (mem_ack && (cnt_r == CNT_LAST)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REFILL;
        end
      end
      ST_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {lat_addr_r, 2'b00};
        mem_wdata = lat_wdata_r;
        mem_be    = lat_be_r;
        if (mem_ack) begin
          cpu_ready    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Line valid bits, refill counter and request latches; a miss invalidates its line up front.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r     <= '0;
      cnt_r       <= '0;
      lat_addr_r  <= '0;
      lat_wdata_r <= '0;
      lat_be_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cpu_req && (cpu_rw || !cpu_hit_s)) begin
            lat_addr_r  <= cpu_addr[ADDR_W-1:2];
            lat_wdata_r <= cpu_wdata;
            lat_be_r    <= cpu_be;
            cnt_r       <= '0;
            if (!cpu_rw) begin
              valid_r[cpu_idx_s] <= 1'b0;
            end
          end
        end
        ST_REFILL: begin
          if (mem_ack) begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              valid_r[lat_idx_s] <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag and data arrays; contents only matter where valid_r is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_REFILL) && mem_ack) begin
      data_r[lat_idx_s][cnt_r] <= mem_rdata;
      if (cnt_r == CNT_LAST) begin
        tag_r[lat_idx_s] <= lat_tag_s;
      end
    end else if (!reset && (state_r == ST_WRITE) && mem_ack && lat_hit_s) begin
      data_r[lat_idx_s][lat_word_s] <= merge_bytes(data_r[lat_idx_s][lat_word_s], lat_wdata_r, lat_be_r);
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a line-presence model plus a flat memory image predicts
// every CPU response and the DRAM traffic behind it; a DRAM model with random ack latency.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_rw = 1'b0;
  logic [11:0] cpu_addr = 12'h000;
  logic [31:0] cpu_wdata = 32'h0;
  logic [3:0]  cpu_be = 4'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, busy, mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  dcache_ctrl dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          nmem;
    int          start;
  } exp_t;

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
  } mem_t;

  exp_t        exp_q[$];
  mem_t        mem_log[$];
  logic [31:0] dram    [1024];
  logic [31:0] ref_mem [1024];
  bit          ref_valid [16];
  logic [3:0]  ref_tag   [16];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int fixed_lat = 2;
  bit force_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] byte_write(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // DRAM: each access is acked cur_lat cycles after mem_req first appears.
  bit          active = 1'b0;
  int          wcnt = 0;
  int          cur_lat = 0;
  logic [48:0] cap_req = 49'h0;
  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (force_ack) begin
      force_ack = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
    end else if (reset || !mem_req) begin
      active = 1'b0;
    end else begin
      if (!active) begin
        active  = 1'b1;
        wcnt    = 0;
        cur_lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
        cap_req = {mem_we, mem_addr, mem_wdata, mem_be};
      end else begin
        check("mem_stable", {15'h0, mem_we, mem_addr, mem_wdata, mem_be}, {15'h0, cap_req});
      end
      if (wcnt == cur_lat) begin
        mem_ack = 1'b1;
        active  = 1'b0;
        if (mem_we) dram[mem_addr[11:2]] = byte_write(dram[mem_addr[11:2]], mem_wdata, mem_be);
        else        mem_rdata = dram[mem_addr[11:2]];
        mem_log.push_back('{mem_we, mem_addr, mem_wdata, mem_be, cur_lat});
      end else begin
        wcnt++;
      end
    end
  end

  // Monitor: idle-output rules every cycle, scoreboard pop on every cpu_ready.
  always @(negedge clk) begin : monitor
    exp_t e;
    mem_t m;
    int   sum, explat;
    #1;
    if (!reset) begin
      if (!mem_req) check("mem_idle_zero", {mem_we, mem_addr, mem_wdata, mem_be}, 64'h0);
      if (!cpu_ready) begin
        check("rdata_zero", cpu_rdata, 64'h0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'h1, 64'h0);
      end else begin
        e = exp_q.pop_front();
        if (!e.rw) check("rdata", cpu_rdata, e.rdata);
        check("mem_count", mem_log.size(), e.nmem);
        sum = 0;
        for (int k = 0; k < mem_log.size() && k < e.nmem; k++) begin
          m = mem_log[k];
          check("mem_we", m.we, e.rw);
          if (e.rw) begin
            check("mem_addr", m.addr, {e.addr[11:2], 2'b00});
            check("mem_wdata", m.wdata, e.wdata);
            check("mem_be", m.be, e.be);
          end else begin
            check("mem_addr", m.addr, {e.addr[11:4], 4'h0} + 12'(4 * k));
            check("mem_be", m.be, 4'hF);
          end
          sum += m.lat + 1;
        end
        explat = e.rw ? sum : ((e.nmem == 0) ? 0 : sum + 1);
        check("latency", cyc - e.start, explat);
        mem_log.delete();
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    cpu_req = 1'b0;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    mem_log.delete();
    model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cpu_req = 1'b0;
    end
  endtask

  // Issue one request, record its expected outcome, hold it until cpu_ready.
  task automatic do_req(input bit rw, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit scramble);
    exp_t     e;
    logic [3:0] idx, tg;
    int       n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    idx = addr[7:4];
    tg  = addr[11:8];
    e.rw = rw; e.addr = addr; e.wdata = wdata; e.be = be; e.start = cyc; e.rdata = 32'h0;
    if (rw) begin
      ref_mem[addr[11:2]] = byte_write(ref_mem[addr[11:2]], wdata, be);
      e.nmem = 1;
    end else begin
      e.nmem = (ref_valid[idx] && ref_tag[idx] == tg) ? 0 : 4;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      e.rdata = ref_mem[addr[11:2]];
    end
    exp_q.push_back(e);
    n = 0;
    forever begin
      #2;
      if (cpu_ready) begin
        cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        break;
      end
      if (n == 300) begin
        check("req_timeout", 64'h0, 64'h1);
        hard_reset();
        break;
      end
      if (scramble && busy && !mem_ack) begin
        cpu_rw = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_be = $urandom;
      end else begin
        cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
      end
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : watchdog
    #400000;
    check("watchdog", 64'h0, 64'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin : stim
    int acks, n;
    for (int i = 0; i < 1024; i++) begin
      dram[i]    = $urandom;
      ref_mem[i] = dram[i];
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    check("reset_busy", busy, 64'h0);
    check("reset_ready", cpu_ready, 64'h0);
    check("reset_mem_req", mem_req, 64'h0);
    check("reset_rdata", cpu_rdata, 64'h0);

    // Line 0x100..0x10C with A1 = AAAA_AAAA, fixed ack delay 2.
    dram[64] = 32'hA000_0000; dram[65] = 32'hAAAA_AAAA;
    dram[66] = 32'hA222_2222; dram[67] = 32'hA333_3333;
    for (int i = 64; i < 68; i++) ref_mem[i] = dram[i];
    fixed_lat = 2;
    do_req(1'b0, 12'h104, 32'h0, 4'h0, 1'b0);
    do_req(1'b0, 12'h10C, 32'h0, 4'h0, 1'b0);
    do_req(1'b1, 12'h104, 32'h1234_5678, 4'b0011, 1'b0);
    do_req(1'b0, 12'h104, 32'h0, 4'h0, 1'b0);
    idle(1);

    fixed_lat = 1;
    do_req(1'b1, 12'h204, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_req(1'b0, 12'h104, 32'h0, 4'h0, 1'b0);
    do_req(1'b0, 12'h204, 32'h0, 4'h0, 1'b0);
    do_req(1'b0, 12'h104, 32'h0, 4'h0, 1'b0);
    do_req(1'b0, 12'h504, 32'h0, 4'h0, 1'b0);
    do_req(1'b0, 12'h104, 32'h0, 4'h0, 1'b0);
    idle(1);

    // Reset on the cycle of the second refill ack.
    fixed_lat = 2;
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h304;
    acks = 0;
    n = 0;
    while (acks < 2 && n < 100) begin
      #2;
      if (mem_ack) acks++;
      if (acks < 2) begin
        @(negedge clk);
        n++;
      end
    end
    check("reset_abort_acks_seen", acks, 64'd2);
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    #2;
    check("abort_mem_req", mem_req, 64'h0);
    check("abort_busy", busy, 64'h0);
    reset = 1'b0;
    exp_q.delete();
    mem_log.delete();
    model_reset();
    do_req(1'b0, 12'h104, 32'h0, 4'h0, 1'b0);
    idle(1);

    // Stray ack while idle, then refills with the CPU inputs wandering while busy.
    force_ack = 1'b1;
    idle(3);
    do_req(1'b0, 12'h104, 32'h0, 4'h0, 1'b0);
    do_req(1'b0, 12'h6A8, 32'h0, 4'h0, 1'b1);
    do_req(1'b1, 12'h6A4, 32'h5555_AAAA, 4'b1010, 1'b1);
    do_req(1'b0, 12'h6A4, 32'h0, 4'h0, 1'b0);
    idle(1);

    fixed_lat = -1;
    repeat (250) begin
      logic [11:0] a;
      a = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
      do_req(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    check("scoreboard_drained", exp_q.size(), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
